// File: rtl/input_handshake.sv
// Debounced "data ready" key captures 18 switches into a one-word buffer read by a stalling processor.
// Latency: button held from edge 1 -> data_valid after edge 3+DEBOUNCE_CYCLES; read consumes at the closing edge.
// Backpressure: wait_request stalls a reader while empty; a confirm into a full, unread buffer sets sticky overrun.
module input_handshake #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] switches,
    input  logic        confirm_button,
    input  logic        read_request,
    output logic [31:0] read_data,
    output logic        data_valid,
    output logic        wait_request,
    output logic        overrun,
    output logic [7:0]  read_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic          sync1;
    logic          s;
    logic          db;
    logic          prev_db;
    logic [CW-1:0] cnt;
    logic          confirm;
    state_t        state;
    logic [17:0]   buffer;

    // Two-flop synchronizer bringing the asynchronous key into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= confirm_button;
            s     <= sync1;
        end
    end

    // Debouncer: db follows s only after DEBOUNCE_CYCLES consecutive disagreeing cycles; prev_db delays db for edge detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            db      <= 1'b0;
            prev_db <= 1'b0;
            cnt     <= '0;
        end else begin
            prev_db <= db;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Only the press (rising debounced level) is an event; release is ignored.
    assign confirm = db & ~prev_db;

    // Buffer FSM: capture on confirm, consume on read, flag confirms that arrive while an unread word is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            buffer     <= '0;
            overrun    <= 1'b0;
            read_count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (confirm) begin
                        buffer <= switches;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (read_request) begin
                        read_count <= read_count + 8'd1;
                        if (confirm) begin
                            // Old word leaves and new word lands at the same edge, so nothing is lost.
                            buffer <= switches;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (confirm) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign data_valid   = (state == FULL);
    assign read_data    = {14'b0, buffer};
    assign wait_request = read_request & (state == EMPTY);

endmodule

// File: tb/tb_input_handshake.sv
module tb_input_handshake;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] switches = '0;
    logic        confirm_button = 1'b0;
    logic        read_request = 1'b0;
    logic [31:0] read_data;
    logic        data_valid;
    logic        wait_request;
    logic        overrun;
    logic [7:0]  read_count;

    int checks = 0;
    int errors = 0;

    // Reference model state (updated once per rising edge from the inputs present at that edge)
    bit          m_b1, m_b2, m_db, m_prev_db, m_full, m_over;
    logic [17:0] m_buf = '0;
    int          m_rc = 0;
    bit          s_hist[$];

    input_handshake #(.DEBOUNCE_CYCLES(D)) dut (
        .clock          (clock),
        .reset          (reset),
        .switches       (switches),
        .confirm_button (confirm_button),
        .read_request   (read_request),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .wait_request   (wait_request),
        .overrun        (overrun),
        .read_count     (read_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: db flips once the last D synchronized samples all disagree with it.
    task automatic model_edge();
        bit conf, s_cur, all_diff;
        if (reset) begin
            m_b1 = 0; m_b2 = 0; m_db = 0; m_prev_db = 0;
            m_full = 0; m_buf = '0; m_over = 0; m_rc = 0;
            s_hist.delete();
        end else begin
            conf = m_db && !m_prev_db;
            if (!m_full) begin
                if (conf) begin m_buf = switches; m_full = 1; end
            end else if (read_request) begin
                m_rc = (m_rc + 1) % 256;
                if (conf) m_buf = switches;
                else m_full = 0;
            end else if (conf) begin
                m_over = 1;
            end
            s_cur = m_b2;
            m_prev_db = m_db;
            s_hist.push_back(s_cur);
            if (s_hist.size() > D) s_hist.delete(0);
            all_diff = 1;
            foreach (s_hist[i]) if (s_hist[i] == m_db) all_diff = 0;
            if (s_hist.size() == D && all_diff) m_db = !m_db;
            m_b2 = m_b1;
            m_b1 = confirm_button;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1; confirm_button = 0; read_request = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic wait_dv(output bit ok);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (data_valid === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1; read_request = 1; confirm_button = 1; switches = 18'h3FFFF;
        tick(); tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b want 0", data_valid); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", read_data); end
        checks++; if (read_count !== 8'h0) begin errors++; $display("FAIL reset_rc got %0d want 0", read_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got %0b want 0", overrun); end
        checks++; if (wait_request !== 1'b1) begin errors++; $display("FAIL reset_wait got %0b want 1", wait_request); end
        reset = 0; read_request = 0; confirm_button = 0;
        #1;
        checks++; if (wait_request !== 1'b0) begin errors++; $display("FAIL idle_wait got %0b want 0", wait_request); end
    endtask

    task automatic test_basic_capture();
        do_reset();
        switches = 18'h2A5A5;
        confirm_button = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (data_valid !== (k >= 7)) begin
                errors++; $display("FAIL basic_dv edge %0d got %0b want %0b", k, data_valid, (k >= 7));
            end
            checks++;
            if (dut.db !== (k >= 6)) begin
                errors++; $display("FAIL basic_db edge %0d got %0b want %0b", k, dut.db, (k >= 6));
            end
            if (k >= 7) begin
                checks++;
                if (read_data !== 32'h0002A5A5) begin
                    errors++; $display("FAIL basic_rd edge %0d got %h want 0002a5a5", k, read_data);
                end
            end
        end
        confirm_button = 0;
        repeat (8) tick();
    endtask

    task automatic test_glitch();
        do_reset();
        switches = 18'h12345;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                confirm_button = (c < 3);
                tick();
                checks++;
                if (data_valid !== 1'b0 || dut.db !== 1'b0) begin
                    errors++; $display("FAIL glitch r%0d c%0d got dv=%0b db=%0b want 0 0", r, c, data_valid, dut.db);
                end
            end
        end
        confirm_button = 0;
        repeat (6) tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL glitch_settle got dv=%0b want 0", data_valid); end
    endtask

    task automatic test_stall_read();
        bit found;
        reset = 1; read_request = 1; confirm_button = 0;
        tick(); tick();
        reset = 0;
        switches = 18'h00011;
        confirm_button = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (data_valid === 1'b1) begin
                found = 1;
                checks++; if (wait_request !== 1'b0) begin errors++; $display("FAIL stall_wait_full got %0b want 0", wait_request); end
                checks++; if (read_data !== 32'h11) begin errors++; $display("FAIL stall_rd got %h want 00000011", read_data); end
                tick();
                checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed_dv got %0b want 0", data_valid); end
                checks++; if (read_count !== 8'd1) begin errors++; $display("FAIL stall_rc got %0d want 1", read_count); end
            end else begin
                checks++; if (wait_request !== 1'b1) begin errors++; $display("FAIL stall_wait cyc %0d got %0b want 1", k, wait_request); end
                tick();
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL stall_timeout got no data_valid want data_valid within 20 cycles"); end
        read_request = 0; confirm_button = 0;
        repeat (8) tick();
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        switches = 18'h1; confirm_button = 1;
        wait_dv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL overrun_capture_timeout got dv=%0b want 1", data_valid); end
        confirm_button = 0;
        repeat (8) tick();
        switches = 18'h2; confirm_button = 1;
        repeat (10) tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0b want 1", overrun); end
        checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL overrun_rd got %h want 00000001", read_data); end
        read_request = 1; tick(); read_request = 0;
        checks++; if (read_count !== 8'd1) begin errors++; $display("FAIL overrun_rc got %0d want 1", read_count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL overrun_dv got %0b want 0", data_valid); end
        confirm_button = 0;
        repeat (8) tick();
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        switches = 18'h3; confirm_button = 1;
        wait_dv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_capture_timeout got dv=%0b want 1", data_valid); end
        confirm_button = 0;
        repeat (8) tick();
        switches = 18'h4; confirm_button = 1;
        repeat (6) tick();
        checks++; if (read_data !== 32'h3) begin errors++; $display("FAIL simul_pre_rd got %h want 00000003", read_data); end
        read_request = 1; tick(); read_request = 0;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL simul_dv got %0b want 1", data_valid); end
        checks++; if (read_data !== 32'h4) begin errors++; $display("FAIL simul_rd got %h want 00000004", read_data); end
        checks++; if (read_count !== 8'd1) begin errors++; $display("FAIL simul_rc got %0d want 1", read_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ov got %0b want 0", overrun); end
    endtask

    task automatic test_reset_mid();
        // Still FULL from the previous scenario; force an overrun so reset has something to clear.
        confirm_button = 0;
        repeat (8) tick();
        confirm_button = 1;
        repeat (8) tick();
        checks++; if (overrun !== 1'b1 || data_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got ov=%0b dv=%0b want 1 1", overrun, data_valid); end
        read_request = 1; reset = 1;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_dv got %0b want 0", data_valid); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL mid_rd got %h want 0", read_data); end
        checks++; if (read_count !== 8'd0) begin errors++; $display("FAIL mid_rc got %0d want 0", read_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_ov got %0b want 0", overrun); end
        checks++; if (wait_request !== 1'b1) begin errors++; $display("FAIL mid_wait got %0b want 1", wait_request); end
        reset = 0; read_request = 0; confirm_button = 0;
        repeat (7) tick();
        for (int i = 0; i < 256; i++) begin
            switches = 18'($urandom);
            confirm_button = 1;
            repeat (8) tick();
            checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL wrap_dv read %0d got %0b want 1", i, data_valid); end
            read_request = 1; tick(); read_request = 0;
            confirm_button = 0;
            checks++; if (read_count !== 8'((i + 1) % 256)) begin errors++; $display("FAIL wrap_rc read %0d got %0d want %0d", i, read_count, (i + 1) % 256); end
            repeat (7) tick();
        end
        checks++; if (read_count !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", read_count); end
    endtask

    task automatic test_random();
        int run = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                confirm_button = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 9);
            end
            run--;
            switches = 18'($urandom);
            read_request = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            #1;
            checks++; if (data_valid !== m_full) begin errors++; $display("FAIL rand_dv cyc %0d got %0b want %0b", c, data_valid, m_full); end
            checks++; if (read_data !== {14'b0, m_buf}) begin errors++; $display("FAIL rand_rd cyc %0d got %h want %h", c, read_data, {14'b0, m_buf}); end
            checks++; if (wait_request !== (read_request && !m_full)) begin errors++; $display("FAIL rand_wait cyc %0d got %0b want %0b", c, wait_request, (read_request && !m_full)); end
            checks++; if (overrun !== m_over) begin errors++; $display("FAIL rand_ov cyc %0d got %0b want %0b", c, overrun, m_over); end
            checks++; if (read_count !== 8'(m_rc)) begin errors++; $display("FAIL rand_rc cyc %0d got %0d want %0d", c, read_count, m_rc); end
            tick();
        end
        reset = 0; read_request = 0; confirm_button = 0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic_capture();
        test_glitch();
        test_stall_read();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_handshake.md
INPUT_HANDSHAKE -- requirements
Module: input_handshake

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized cycles required to accept a button level change; legal range 1..2^20.
REQ-002 The block SHALL have the following ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- switches  input  18  user data, sampled at capture.
- confirm_button  input  1  raw, asynchronous, active-high user "data ready" key.
- read_request  input  1  high while the processor executes an input instruction.
- read_data  output  32  captured word, zero-extended from 18 bits.
- data_valid  output  1  captured word present and unread.
- wait_request  output  1  processor must stall (halt PC) this cycle.
- overrun  output  1  sticky: a confirm was lost because the buffer was full.
- read_count  output  8  number of words consumed, modulo 256.

Function
REQ-003 confirm_button SHALL pass through a 2-flop synchronizer; the second flop's output is called s.
REQ-004 The debouncer SHALL hold a level db and a counter cnt of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
- s == db: cnt <= 0.
- s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
- Otherwise cnt <= cnt+1.
REQ-005 Any single-cycle disagreement between s and db SHALL restart the count; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change db.
REQ-006 A confirm event SHALL be one cycle long: db == 1 and registered prev_db == 0; releasing the button SHALL generate no event.
REQ-007 The FSM SHALL have exactly two states, EMPTY (data_valid=0) and FULL (data_valid=1).
REQ-008 EMPTY with confirm: buffer <= switches, state <= FULL.
REQ-009 FULL with read_request and no confirm: state <= EMPTY, read_count <= read_count+1; buffer holds its value.
REQ-010 FULL with read_request and confirm in the same cycle: the old word is consumed, read_count increments, buffer <= switches, state stays FULL, overrun unchanged.
REQ-011 FULL with confirm and no read_request: buffer, state and read_count are unchanged, overrun <= 1.
REQ-012 EMPTY with read_request and no confirm: no state change.
REQ-013 read_data SHALL be {14'b0, buffer} at all times (registered, no combinational path from switches).
REQ-014 wait_request SHALL be combinational: read_request AND state == EMPTY; it SHALL be 0 whenever read_request is 0.
REQ-015 A read SHALL complete in the cycle read_request is high with data_valid high; read_data is valid for that whole cycle and the consume happens at its closing edge.
REQ-016 Latency: with confirm_button first sampled high at edge 1 and held, db rises after edge 2+DEBOUNCE_CYCLES and data_valid rises after edge 3+DEBOUNCE_CYCLES; switches are captured at that same edge.
REQ-017 read_count SHALL wrap from 255 to 0 with no flag.
REQ-018 overrun SHALL be cleared only by reset.

Reset
REQ-019 While reset is high at a rising edge, the block SHALL set: sync flops, db, prev_db, cnt = 0; state = EMPTY; buffer = 0; overrun = 0; read_count = 0.
REQ-020 Reset SHALL take priority over every other event, including mid-debounce and FULL with a simultaneous read; the pending word is discarded and not counted.
REQ-021 With read_request high during reset, wait_request SHALL be 1, because state is EMPTY.
REQ-022 After reset deasserts with the button held high, the button SHALL be treated as a fresh press: a confirm occurs 2+DEBOUNCE_CYCLES+1 edges later.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 Basic capture: switches=18'h2A5A5, button high from edge 1 -> data_valid=1 and read_data=32'h0002A5A5 after edge 7, not before.
REQ-024 Glitch rejection: button high for 3 cycles, low for 2, repeated 5 times -> data_valid stays 0, db stays 0.
REQ-025 Stall then read: read_request held high from reset release, then press with switches=18'h00011 -> wait_request=1 until data_valid rises; in the first cycle with data_valid=1, wait_request=0 and read_data=32'h11; after that edge data_valid=0 and read_count=1.
REQ-026 Overrun: capture 18'h1, do not read, release the button and press again with 18'h2 -> overrun=1 and read_data stays 32'h1; after a read, read_count=1 and overrun is still 1.
REQ-027 Simultaneous events: FULL with 18'h3, next confirm aligned to a cycle with read_request=1 and switches=18'h4 -> after that edge data_valid=1, read_data=32'h4, read_count incremented, overrun=0.
REQ-028 Reset mid-operation: reset asserted in FULL with read_request=1 -> next cycle data_valid=0, read_data=0, read_count=0, overrun=0; 256 completed reads after that -> read_count=0.
